dac_sample_scheduler: RTL and testbench

Sequences sample delivery into the delta-sigma modulator. Upstream writes samples through a valid/ready handshake into a small FIFO. The block releases one sample to the modulator every `div` clocks, which sets the oversampling period. It also handles start-up priming, underrun and mute; on underrun or mute it substitutes midscale so the analogue output never sees a DC step.

---
 rtl/dac_pkg.sv | 19 +
 rtl/dac_sample_fifo.sv | 57 +++++
 rtl/dac_sample_scheduler.sv | 135 +++++++++++++
 tb/tb_dac_sample_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared state encoding and constants for the DAC sample scheduler.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2,
        UNDERRUN = 2'd3
    } dac_state_t;

    localparam int MIN_DIV       = 2;
    localparam int MAX_DATA_SIZE = 64;

    // Offset-binary zero; callers keep the low data_size bits.
    function automatic logic [MAX_DATA_SIZE-1:0] midscale(input int unsigned data_size);
        return MAX_DATA_SIZE'(1) << (data_size - 1);
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Small synchronous sample FIFO; a pushed entry becomes visible at the head one cycle later.
module dac_sample_fifo #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_SIZE-1:0]    wr_data,
    output logic [DATA_SIZE-1:0]    head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // NOTE: the storage array is deliberately not reset; pointers and level alone define its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments keep every register update in this block order-independent.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Releases one FIFO sample to the delta-sigma modulator every latched_div clocks,
// substituting midscale on mute or underrun.
module dac_sample_scheduler
    import dac_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int PRIME_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DIV_WIDTH-1:0]         div,
    input  logic                         mute,
    input  logic [DATA_SIZE-1:0]         s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DATA_SIZE-1:0]         dac_data,
    output logic                         dac_load,
    output logic                         underrun,
    input  logic                         clr_underrun,
    output logic [1:0]                   state,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int                        LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [MAX_DATA_SIZE-1:0]  MID_WIDE  = midscale(DATA_SIZE);
    localparam logic [DATA_SIZE-1:0]      MIDSCALE  = MID_WIDE[DATA_SIZE-1:0];
    localparam logic [DIV_WIDTH-1:0]      MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

    dac_state_t           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DATA_SIZE-1:0] data_d;
    logic                 load_d;
    logic                 underrun_d;
    logic                 set_underrun;
    logic                 tick;
    logic                 push, pop, flush;
    logic                 full, empty;
    logic [DATA_SIZE-1:0] head;

    // s_ready reflects the pre-pop level, so a full FIFO never accepts even on a pop cycle.
    assign s_ready = reset && !full;
    assign push    = s_valid && s_ready;
    assign state   = state_q;
    assign tick    = ((state_q == RUN) || (state_q == UNDERRUN)) && (cnt_q == div_q - 1'b1);

    dac_sample_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (s_data),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        data_d       = dac_data;
        load_d       = 1'b0;
        set_underrun = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            flush   = 1'b1;
            data_d  = MIDSCALE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_d  = MIDSCALE;
                    div_d   = (div < MIN_DIV_W) ? MIN_DIV_W : div;
                    state_d = PRIME;
                end
                PRIME: begin
                    if (fifo_level >= LVL_W'(PRIME_LEVEL)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN, UNDERRUN: begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        load_d = 1'b1;
                        if (!empty) begin
                            pop     = 1'b1;
                            data_d  = mute ? MIDSCALE : head;
                            state_d = RUN;
                        end else begin
                            data_d       = MIDSCALE;
                            state_d      = UNDERRUN;
                            set_underrun = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        underrun_d = set_underrun || (underrun && !clr_underrun);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= MIN_DIV_W;
            dac_data <= MIDSCALE;
            dac_load <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dac_data <= data_d;
            dac_load <= load_d;
            underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed plus randomized bench for dac_sample_scheduler against a queue-and-arithmetic reference model.
module tb_dac_sample_scheduler;

    localparam int          DEPTH = 4;
    localparam int          PRIME = 2;
    localparam logic [31:0] MID   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset, enable, mute, s_valid, clr_underrun;
    logic [15:0] div;
    logic [31:0] s_data;
    logic        s_ready, dac_load, underrun;
    logic [31:0] dac_data;
    logic [1:0]  state;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    bit rand_data = 0;
    int n;

    // Reference model: sample queue, state code, and tick phase derived from the cycle index.
    int          m_st;
    logic [31:0] m_q[$];
    logic [31:0] m_dac;
    logic        m_load, m_under;
    int          m_ldiv, m_t0, cyc;

    always #5 clk = ~clk;

    dac_sample_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .div          (div),
        .mute         (mute),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .dac_data     (dac_data),
        .dac_load     (dac_load),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .state        (state),
        .fifo_level   (fifo_level)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_tick_next();
        return (m_st >= 2) && (((cyc - m_t0) % m_ldiv) == m_ldiv - 1);
    endfunction

    task automatic model_step();
        bit          push, tick, set_u;
        logic [31:0] v;
        if (!reset) begin
            m_st = 0; m_q.delete(); m_dac = MID; m_load = 0; m_under = 0; m_ldiv = 2;
        end else begin
            push   = s_valid && (m_q.size() < DEPTH);
            tick   = model_tick_next();
            set_u  = 0;
            m_load = 0;
            if (!enable) begin
                m_st = 0; m_q.delete(); m_dac = MID;
            end else begin
                case (m_st)
                    0: begin
                        m_ldiv = (div < 2) ? 2 : int'(div);
                        m_st   = 1;
                    end
                    1: if (m_q.size() >= PRIME) begin
                        m_st = 2;
                        m_t0 = cyc + 1;
                    end
                    default: if (tick) begin
                        m_load = 1;
                        if (m_q.size() > 0) begin
                            v     = m_q.pop_front();
                            m_dac = mute ? MID : v;
                            m_st  = 2;
                        end else begin
                            m_dac = MID;
                            m_st  = 3;
                            set_u = 1;
                        end
                    end
                endcase
                if (push) m_q.push_back(s_data);
            end
            m_under = set_u || (m_under && !clr_underrun);
        end
        cyc++;
    endtask

    task automatic cycle();
        if (rand_data) s_data = $urandom;
        @(posedge clk);
        model_step();
        #1;
        check("dac_data", dac_data, m_dac);
        check("dac_load", dac_load, m_load);
        check("underrun", underrun, m_under);
        check("state", state, m_st);
        check("fifo_level", fifo_level, m_q.size());
        check("s_ready", s_ready, reset && (m_q.size() < DEPTH));
    endtask

    task automatic wait_load(input int limit, output int cnt);
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (dac_load !== 1'b1 && cnt < limit);
        check("load_seen", dac_load, 1'b1);
    endtask

    task automatic run_to_tick(input int limit);
        for (int i = 0; i < limit && !model_tick_next(); i++) cycle();
    endtask

    task automatic push_word(input logic [31:0] d);
        s_valid = 1; s_data = d;
        cycle();
        s_valid = 0;
    endtask

    initial begin
        reset = 0; enable = 0; div = 16'd4; mute = 0; s_data = '0; s_valid = 0; clr_underrun = 0;
        cyc = 0; m_t0 = 0; m_st = 0; m_dac = MID; m_load = 0; m_under = 0; m_ldiv = 2;

        // Reset and priming
        repeat (3) cycle();
        reset = 1;
        cycle();
        check("rst_dac", dac_data, MID);
        check("rst_load", dac_load, 1'b0);
        check("rst_state", state, 2'd0);
        check("rst_ready", s_ready, 1'b1);

        enable = 1; div = 16'd4;
        cycle();
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        cycle();
        check("prime_run", state, 2'd2);
        wait_load(10, n);
        check("first_latency", n, 4);
        check("first_data", dac_data, 32'h1111_1111);
        wait_load(10, n);
        check("second_period", n, 4);
        check("second_data", dac_data, 32'h2222_2222);

        // Underrun and recovery
        wait_load(10, n);
        check("ur_data", dac_data, MID);
        check("ur_flag", underrun, 1'b1);
        check("ur_state", state, 2'd3);
        push_word(32'h3333_3333);
        wait_load(10, n);
        check("recover_data", dac_data, 32'h3333_3333);
        check("recover_state", state, 2'd2);
        clr_underrun = 1;
        cycle();
        clr_underrun = 0;
        check("clr_underrun", underrun, 1'b0);
        run_to_tick(10);
        clr_underrun = 1;
        cycle();
        clr_underrun = 0;
        check("set_wins", underrun, 1'b1);

        // Divider clamp and mid-run divider change
        for (int d = 0; d < 2; d++) begin
            enable = 0; cycle();
            div = 16'(d); enable = 1; s_valid = 1; rand_data = 1;
            wait_load(30, n);
            wait_load(10, n);
            check("clamp_period_a", n, 2);
            wait_load(10, n);
            check("clamp_period_b", n, 2);
        end
        enable = 0; cycle();
        div = 16'd4; enable = 1;
        wait_load(30, n);
        div = 16'd8;
        wait_load(20, n);
        check("div_ignored_a", n, 4);
        wait_load(20, n);
        check("div_ignored_b", n, 4);

        // Full FIFO with continuous upstream pressure
        enable = 0; cycle(); cycle();
        enable = 1; div = 16'd4;
        for (int i = 0; i < 20 && fifo_level !== 3'd4; i++) cycle();
        check("full_level", fifo_level, 3'd4);
        check("full_ready", s_ready, 1'b0);
        repeat (40) cycle();

        // Mute
        s_valid = 0; rand_data = 0; enable = 0; cycle();
        enable = 1; div = 16'd4; cycle();
        push_word(32'hAAAA_AAAA);
        push_word(32'hBBBB_BBBB);
        mute = 1;
        wait_load(20, n);
        check("mute_data_a", dac_data, MID);
        check("mute_level_a", fifo_level, 3'd1);
        wait_load(20, n);
        check("mute_data_b", dac_data, MID);
        check("mute_level_b", fifo_level, 3'd0);
        mute = 0;

        // Disable on a tick with three samples queued
        enable = 0; cycle();
        enable = 1; div = 16'd4; cycle();
        for (int i = 0; i < 3; i++) push_word($urandom);
        run_to_tick(20);
        check("dis_pre_level", fifo_level, 3'd3);
        enable = 0;
        cycle();
        check("dis_load", dac_load, 1'b0);
        check("dis_state", state, 2'd0);
        check("dis_level", fifo_level, 3'd0);
        check("dis_data", dac_data, MID);
        check("dis_underrun_kept", underrun, 1'b1);

        // Reset on a tick with three samples queued
        enable = 1; div = 16'd4; cycle();
        for (int i = 0; i < 3; i++) push_word($urandom);
        run_to_tick(20);
        reset = 0;
        cycle();
        check("rstmid_load", dac_load, 1'b0);
        check("rstmid_state", state, 2'd0);
        check("rstmid_level", fifo_level, 3'd0);
        check("rstmid_data", dac_data, MID);
        check("rstmid_underrun", underrun, 1'b0);
        check("rstmid_ready", s_ready, 1'b0);
        reset = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            enable       = ($urandom_range(0, 31) != 0);
            reset        = ($urandom_range(0, 199) != 0);
            mute         = ($urandom_range(0, 7) == 0);
            s_valid      = 1'($urandom_range(0, 1));
            clr_underrun = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 6));
            s_data = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
